// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Brief    : 16x-oversampling 8N1 UART receiver with a valid/ready byte
//            handshake, start-glitch rejection, framing and overrun flags.
//            Define UART_RX_PARITY_EN to receive 8E1 frames and get parity_err.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_busy
);

    localparam int c_OS_RAW = clk_freq / (baud_rate * 16);
    localparam int OS_DIV   = (c_OS_RAW < 1) ? 1 : c_OS_RAW;
    localparam int c_TICK_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OS_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic                r_sync1;
    logic                r_sync2;
    logic                w_rx_s;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [3:0]          r_os_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                w_tick;
    logic                w_mid;
    logic                w_deliver;
    logic [7:0]          r_dout;
    logic                r_rx_valid;
    logic                r_frame_err;
    logic                r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                r_par_bit;
    logic                r_parity_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s    = r_sync2;
    assign w_tick    = (r_tick_cnt == c_TICK_LAST);
    assign w_mid     = w_tick && (r_os_cnt == 4'd15);
    assign w_deliver = (r_state == S_STOP) && w_mid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // Half a bit in: a line already back high was only a glitch.
                if (w_tick && (r_os_cnt == 4'd7)) begin
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_mid && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_mid) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_mid) begin
                    w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counters sit at zero in IDLE so they start aligned with the start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_os_cnt   <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_par_bit  <= 1'b0;
`endif
        end else if (r_state == S_IDLE) begin
            r_tick_cnt <= '0;
            r_os_cnt   <= 4'd0;
            r_bit_cnt  <= 3'd0;
        end else begin
            if (w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            if (w_tick) begin
                if ((r_state == S_START) && (r_os_cnt == 4'd7)) begin
                    r_os_cnt <= 4'd0;
                end else begin
                    r_os_cnt <= r_os_cnt + 4'd1;
                end
            end
            if ((r_state == S_DATA) && w_mid) begin
                r_shift   <= {w_rx_s, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if ((r_state == S_PARITY) && w_mid) begin
                r_par_bit <= w_rx_s;
            end
`endif
        end
    end

    // A byte arriving while the holder is full and not being taken is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout       <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;
            if (w_deliver) begin
                if (r_rx_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_dout       <= r_shift;
                    r_frame_err  <= !w_rx_s;
                    r_rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    r_parity_err <= (^r_shift) ^ r_par_bit;
`endif
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign rx_busy    = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os
// Brief    : Scoreboard bench for uart_rx_os at default rates (96 clk/bit).
//            Define UART_RX_PARITY_EN to exercise the 8E1 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int BIT = 96;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_os dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ovr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b, input bit chk);
        rx = b;
        clks(40);
        if (chk) check("busy_in_frame", rx_busy, 1);
        clks(BIT - 40);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic par, input bit chk);
        drive_bit(1'b0, chk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], chk);
        if (HAS_PAR) drive_bit(par, chk);
        drive_bit(stop, chk);
    endtask

    task automatic push(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d  = d;
        e.fe = fe;
        e.pe = pe;
        q.push_back(e);
    endtask

    // Monitor: compares each byte once, when it is first presented.
    initial begin : monitor
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (overrun) ovr_cnt++;
            if (!rx_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, expected no delivery", dout);
                end else begin
                    e = q.pop_front();
                    check("dout", dout, e.d);
                    check("frame_err", frame_err, e.fe);
`ifdef UART_RX_PARITY_EN
                    check("parity_err", parity_err, e.pe);
`endif
                end
            end
            if (rx_valid && rx_ready) seen = 1'b0;
        end
    end

    initial begin : stim
        // Reset values
        clks(3);
        check("rst_dout", dout, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rx_busy", rx_busy, 0);
        rst = 1'b1;
        clks(10);

        // Clean frames, consumer always ready
        rx_ready = 1'b1;
        push(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b0, 1'b1);
        clks(20);
        check("a5_accepted", rx_valid, 0);
        check("a5_idle", rx_busy, 0);
        push(8'h00, 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        push(8'h80, 1'b0, 1'b0);
        send(8'h80, 1'b1, 1'b1, 1'b0);
        clks(20);
        check("no_overrun_clean", ovr_cnt, 0);

        // Start glitch shorter than half a bit
        rx = 1'b0;
        clks(10);
        check("glitch_busy", rx_busy, 1);
        clks(20);
        rx = 1'b1;
        clks(100);
        check("glitch_idle", rx_busy, 0);
        check("glitch_no_valid", rx_valid, 0);
        check("glitch_no_ferr", frame_err, 0);
        check("glitch_no_overrun", ovr_cnt, 0);

        // Stop bit forced low, line held low (break)
        push(8'h3C, 1'b1, 1'b0);
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        clks(500);
        check("break_busy", rx_busy, 1);
        rx = 1'b1;
        clks(20);
        check("break_released", rx_busy, 0);
        clks(BIT * 12);

        // Overrun: consumer stalled across two back-to-back frames
        rx_ready = 1'b0;
        push(8'h11, 1'b0, 1'b0);
        send(8'h11, 1'b1, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0, 1'b0);
        clks(20);
        check("ovr_dout_held", dout, 8'h11);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_pulses", ovr_cnt, 1);
        rx_ready = 1'b1;
        clks(2);
        check("ovr_accepted", rx_valid, 0);

        // Asynchronous reset in bit 4 of 8'hFF
        rx = 1'b0;
        clks(BIT);
        rx = 1'b1;
        clks(4 * BIT + 48);
        rst = 1'b0;
        #1;
        check("midrst_dout", dout, 8'h00);
        check("midrst_valid", rx_valid, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_busy", rx_busy, 0);
        clks(5);
        rst = 1'b1;
        clks(BIT * 8);
        check("post_rst_idle", rx_busy, 0);
        push(8'h5A, 1'b0, 1'b0);
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        clks(20);

`ifdef UART_RX_PARITY_EN
        push(8'h07, 1'b0, 1'b0);
        send(8'h07, 1'b1, 1'b1, 1'b0);
        push(8'h07, 1'b0, 1'b1);
        send(8'h07, 1'b1, 1'b0, 1'b0);
        clks(20);
`endif

        check("overrun_total", ovr_cnt, 1);
        check("all_bytes_seen", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver: recovers 8N1 frames from the serial line driven by the team's UART transmitter (idle high, start 0, LSB first, stop 1).
- Adds input synchronisation, mid-bit sampling, start-glitch rejection, stop-bit framing check and a valid/ready byte handshake with overrun detection.
- Sits between the pad-side rx line and a byte consumer (register file or FIFO) on the system clock.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, line bit rate in bits/s.
- OS_DIV (localparam), clk_freq/(baud_rate*16) truncated, clocks per oversample tick; 6 at defaults; values below 1 are forced to 1.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rx  in  1  asynchronous serial input.
- rx_ready  in  1  consumer accepts dout when high with rx_valid.
- dout  out  8  received byte; stable while rx_valid is high.
- rx_valid  out  1  byte available; held until accepted.
- frame_err  out  1  qualifies dout: 1 = stop bit sampled 0; valid only with rx_valid.
- overrun  out  1  one-clk pulse: completed frame dropped because the holding register was full.
- rx_busy  out  1  high whenever the FSM is not IDLE.
- parity_err  out  1  exists only with UART_RX_PARITY_EN (see Optional Feature).

Behaviour:
- Reset (rst=0, async): 2-FF synchroniser flops=1, FSM=IDLE, all counters=0, dout=8'h00, rx_valid=0, frame_err=0, overrun=0, rx_busy=0. Reset mid-frame discards the partial byte; a held unaccepted byte is lost.
- rx passes through the 2-FF synchroniser -> rx_s. All decisions use rx_s only.
- Tick generator: tick_cnt runs 0..OS_DIV-1; tick is a one-clk pulse at OS_DIV-1. tick_cnt and os_cnt clear to 0 on the IDLE->START transition to align with the start edge.
- os_cnt (4 bit) advances on each tick; bit_cnt (3 bit) counts data bits.
- IDLE: rx_s==0 -> START.
- START: at os_cnt==7 (mid start bit): rx_s==1 -> IDLE (glitch; no output, no flags); rx_s==0 -> DATA with os_cnt=0, bit_cnt=0.
- DATA: at os_cnt==15, shift register <= {rx_s, shift[7:1]} (LSB first), os_cnt=0. After the 8th bit (bit_cnt==7) -> STOP (or PARITY with the option).
- STOP: at os_cnt==15, sample rx_s, then deliver the byte (rules below). rx_s==1 -> IDLE. rx_s==0 -> BREAK.
- BREAK: wait until rx_s==1, then -> IDLE. A held-low line never produces repeated frames.
- Delivery: dout/frame_err load and rx_valid=1 on the clock after the stop sample tick.
- Handshake: transfer occurs on any clk with rx_valid && rx_ready; rx_valid drops next clk unless a new byte loads on that same clk.
- Simultaneous accept and delivery: the old byte is consumed, the new byte loads, rx_valid stays 1, no overrun.
- Delivery while rx_valid=1 and rx_ready=0: the new byte is discarded, dout is unchanged, overrun pulses for 1 clk.
- Latency: start falling edge on rx to rx_valid is about 9.5 bit times + 3 clk (sync + register).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state between DATA and STOP samples the parity bit at os_cnt==15. parity_err = XOR(data, parity bit); it loads alongside dout and is qualified by rx_valid, resets to 0.
- Undefined: 8N1 only; no PARITY state; parity_err port absent.

Test Plan:
- Defaults (OS_DIV=6, 96 clk/bit). Send 8'hA5 8N1, rx_ready=1 -> one rx_valid pulse, dout=8'hA5, frame_err=0, overrun=0; rx_busy high for the whole frame.
- rx low for 30 clk, then high (shorter than half a bit) -> FSM returns to IDLE; rx_valid, frame_err and overrun stay 0.
- Send 8'h3C with stop bit forced 0, line held low 500 clk, then released -> exactly one delivery, dout=8'h3C, frame_err=1; FSM waits in BREAK; no second frame.
- rx_ready=0, send 8'h11 then 8'h22 back to back -> dout stays 8'h11, overrun pulses 1 clk at the second stop. Raise rx_ready -> 8'h11 accepted, rx_valid drops.
- Pull rst low during bit 4 of 8'hFF, release, then send 8'h5A -> all outputs 0 during reset; the only delivered byte is 8'h5A.
- With UART_RX_PARITY_EN: send 8'h07 with parity 1 -> parity_err=0; with parity 0 -> parity_err=1, dout=8'h07.
